// File: rtl/isp_pixel_serializer.sv
// Pixel FIFO plus R/G/B word serializer with frame position tracking and
// start-of-frame / end-of-line / end-of-frame markers.
module isp_pixel_serializer #(
    parameter int unsigned CH_WIDTH   = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [11:0]           x_size,
    input  logic [11:0]           y_size,
    input  logic [3*CH_WIDTH-1:0] pixel_in,
    input  logic                  pixel_valid,
    output logic                  pixel_ready,
    output logic [CH_WIDTH-1:0]   word_out,
    output logic                  word_valid,
    input  logic                  word_ready,
    output logic                  sof,
    output logic                  eol,
    output logic                  eof,
    output logic                  busy
);

    localparam int unsigned PIX_W = 3 * CH_WIDTH;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned POS_W = 12;

    typedef enum logic [1:0] {IDLE, CH_R, CH_G, CH_B} state_t;

    state_t                state, state_nxt;
    logic [PIX_W-1:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count, count_nxt;
    logic [2*CH_WIDTH-1:0] hold, hold_nxt;
    logic [POS_W-1:0]      x, y, xs, ys;
    logic [POS_W-1:0]      x_nxt, y_nxt, xs_nxt, ys_nxt;
    logic [POS_W-1:0]      x_adv, y_adv, ld_x, ld_y;
    logic                  in_frame, in_frame_nxt;
    logic [CH_WIDTH-1:0]   word_nxt;
    logic                  valid_nxt, sof_nxt, eol_nxt, eof_nxt;
    logic                  push, pop, load, hs, last_x, last_y, frame_start;
    logic [PIX_W-1:0]      head;

    assign push      = pixel_valid && pixel_ready;
    assign hs        = word_valid && word_ready;
    assign head      = mem[rd_ptr];
    assign last_x    = (x == xs - POS_W'(1));
    assign last_y    = (y == ys - POS_W'(1));
    assign x_adv     = last_x ? '0 : x + POS_W'(1);
    assign y_adv     = !last_x ? y : (last_y ? '0 : y + POS_W'(1));
    assign count_nxt = count + CNT_W'(push) - CNT_W'(pop);
    assign frame_start = (ld_x == '0) && (ld_y == '0);

    // FIFO storage; written on every accepted pixel
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= pixel_in;
        end
    end

    // Serializer next-state, word/marker and position update
    always_comb begin
        state_nxt    = state;
        pop          = 1'b0;
        load         = 1'b0;
        ld_x         = x;
        ld_y         = y;
        hold_nxt     = hold;
        word_nxt     = word_out;
        valid_nxt    = word_valid;
        sof_nxt      = sof;
        eol_nxt      = eol;
        eof_nxt      = eof;
        x_nxt        = x;
        y_nxt        = y;
        xs_nxt       = xs;
        ys_nxt       = ys;
        in_frame_nxt = in_frame;

        if (hs) begin
            in_frame_nxt = !eof;
        end

        case (state)
            IDLE: begin
                if (count != '0) begin
                    load = 1'b1;
                end
            end
            CH_R: begin
                if (hs) begin
                    state_nxt = CH_G;
                    word_nxt  = hold[2*CH_WIDTH-1:CH_WIDTH];
                    sof_nxt   = 1'b0;
                end
            end
            CH_G: begin
                if (hs) begin
                    state_nxt = CH_B;
                    word_nxt  = hold[CH_WIDTH-1:0];
                    eol_nxt   = last_x;
                    eof_nxt   = last_x && last_y;
                end
            end
            CH_B: begin
                if (hs) begin
                    x_nxt = x_adv;
                    y_nxt = y_adv;
                    ld_x  = x_adv;
                    ld_y  = y_adv;
                    if (count != '0) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        valid_nxt = 1'b0;
                        eol_nxt   = 1'b0;
                        eof_nxt   = 1'b0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A pixel loaded at position (0,0) opens a frame and latches its size
        if (load) begin
            pop       = 1'b1;
            state_nxt = CH_R;
            hold_nxt  = head[2*CH_WIDTH-1:0];
            word_nxt  = head[PIX_W-1:2*CH_WIDTH];
            valid_nxt = 1'b1;
            sof_nxt   = frame_start;
            eol_nxt   = 1'b0;
            eof_nxt   = 1'b0;
            if (frame_start) begin
                xs_nxt = (x_size == '0) ? POS_W'(1) : x_size;
                ys_nxt = (y_size == '0) ? POS_W'(1) : y_size;
            end
        end
    end

    // State, FIFO bookkeeping and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            pixel_ready <= 1'b1;
            hold        <= '0;
            x           <= '0;
            y           <= '0;
            xs          <= POS_W'(1);
            ys          <= POS_W'(1);
            in_frame    <= 1'b0;
            word_out    <= '0;
            word_valid  <= 1'b0;
            sof         <= 1'b0;
            eol         <= 1'b0;
            eof         <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count       <= count_nxt;
            pixel_ready <= (count_nxt != CNT_W'(FIFO_DEPTH));
            hold        <= hold_nxt;
            x           <= x_nxt;
            y           <= y_nxt;
            xs          <= xs_nxt;
            ys          <= ys_nxt;
            in_frame    <= in_frame_nxt;
            word_out    <= word_nxt;
            word_valid  <= valid_nxt;
            sof         <= sof_nxt;
            eol         <= eol_nxt;
            eof         <= eof_nxt;
            busy        <= in_frame_nxt || (count_nxt != '0) || (state_nxt != IDLE);
        end
    end

endmodule
